// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: default widths, the reset
// fetch address, instruction size and the sequencer state encoding.
package pc_sequencer_pkg;

  localparam int unsigned CPU_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam int unsigned INST_BYTES    = 4;

  typedef enum logic [1:0] {
    PCSEQ_BOOT = 2'd0,
    PCSEQ_RUN  = 2'd1,
    PCSEQ_WAIT = 2'd2
  } pcseq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch request channel between the PC sequencer (master) and the IFU (slave).
interface pc_sequencer_if #(
  parameter int unsigned CPU_WIDTH = 32
) ();

  logic                 if_vld;
  logic [CPU_WIDTH-1:0] if_pc;
  logic                 if_rdy;

  modport master (
    output if_vld,
    output if_pc,
    input  if_rdy
  );

  modport slave (
    input  if_vld,
    input  if_pc,
    output if_rdy
  );

endinterface

// File: rtl/pc_sequencer.sv
// Architectural fetch PC owner: arbitrates trap / execute redirect / stall /
// sequential fetch and offers one address at a time to the IFU.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned          CPU_WIDTH = CPU_WIDTH_DEF,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(RESET_PC_DEF),
  parameter int unsigned          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 stall,
  input  logic                 exu_redir_vld,
  input  logic [CPU_WIDTH-1:0] exu_redir_pc,
  input  logic                 trap_vld,
  input  logic [CPU_WIDTH-1:0] trap_pc,
  pc_sequencer_if.master       fetch,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] redir_cnt
);

  localparam logic [CPU_WIDTH-1:0] ALIGN_MASK = ~CPU_WIDTH'(INST_BYTES - 1);
  localparam logic [CPU_WIDTH-1:0] PC_STEP    = CPU_WIDTH'(INST_BYTES);

  pcseq_state_e         state;
  logic [CPU_WIDTH-1:0] pc;
  logic                 pend_vld;
  logic [CPU_WIDTH-1:0] pend_pc;

  logic                 if_vld_c;
  logic                 fire;
  logic                 offer_held;
  logic                 redir;
  logic [CPU_WIDTH-1:0] redir_tgt;
  logic [CPU_WIDTH-1:0] pc_inc;

  // Reset gates the offer directly so no request escapes while rst is high.
  always_comb begin
    if_vld_c = 1'b0;
    if (!rst) begin
      case (state)
        PCSEQ_BOOT: if_vld_c = 1'b0;
        PCSEQ_RUN:  if_vld_c = ena & ~stall;
        PCSEQ_WAIT: if_vld_c = 1'b1;
        default:    if_vld_c = 1'b0;
      endcase
    end
  end

  assign fetch.if_vld = if_vld_c;
  assign fetch.if_pc  = pc;

  assign fire       = if_vld_c & fetch.if_rdy;
  assign offer_held = if_vld_c & ~fetch.if_rdy;

  assign redir     = trap_vld | exu_redir_vld;
  assign redir_tgt = (trap_vld ? trap_pc : exu_redir_pc) & ALIGN_MASK;
  assign pc_inc    = pc + PC_STEP;

  // A redirect arriving while an offer is held is parked in pend_pc so the
  // offered address stays stable; it is applied when that offer fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PCSEQ_BOOT;
      pc       <= RESET_PC;
      pend_vld <= 1'b0;
      pend_pc  <= '0;
      flush    <= 1'b0;
    end else begin
      flush <= redir;

      case (state)
        PCSEQ_BOOT: if (ena)          state <= PCSEQ_RUN;
        PCSEQ_RUN:  if (offer_held)   state <= PCSEQ_WAIT;
        PCSEQ_WAIT: if (fetch.if_rdy) state <= PCSEQ_RUN;
        default:                      state <= PCSEQ_BOOT;
      endcase

      if (redir) begin
        if (offer_held) begin
          pend_vld <= 1'b1;
          pend_pc  <= redir_tgt;
        end else begin
          pc       <= redir_tgt;
          pend_vld <= 1'b0;
        end
      end else if (fire) begin
        if (pend_vld) begin
          pc       <= pend_pc;
          pend_vld <= 1'b0;
        end else begin
          pc <= pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_cnt <= '0;
    end else if (redir && (redir_cnt != '1)) begin
      redir_cnt <= redir_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed walk through the fetch
// scenarios followed by randomized traffic against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, ena, stall;
  logic        exu_redir_vld, trap_vld, if_rdy;
  logic [31:0] exu_redir_pc, trap_pc;

  logic        flush_a, flush_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.CPU_WIDTH(32)) fa ();
  pc_sequencer_if #(.CPU_WIDTH(32)) fb ();
  assign fa.if_rdy = if_rdy;
  assign fb.if_rdy = if_rdy;

  pc_sequencer #(.CPU_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .stall(stall),
    .exu_redir_vld(exu_redir_vld), .exu_redir_pc(exu_redir_pc),
    .trap_vld(trap_vld), .trap_pc(trap_pc),
    .fetch(fa), .flush(flush_a), .redir_cnt(cnt_a)
  );

  pc_sequencer #(.CPU_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .stall(stall),
    .exu_redir_vld(exu_redir_vld), .exu_redir_pc(exu_redir_pc),
    .trap_vld(trap_vld), .trap_pc(trap_pc),
    .fetch(fb), .flush(flush_b), .redir_cnt(cnt_b)
  );

  // Reference model: architectural view of the fetch sequencer.
  logic [31:0] m_pc, m_pend_pc;
  bit          m_booted, m_held, m_pend, m_flush;
  int unsigned m_cnt_a, m_cnt_b;

  logic        o_vld, o_flush;
  logic [31:0] o_pc;
  logic [15:0] o_cnt;
  logic [1:0]  o_cnt_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pend_pc = 32'h0;
    m_booted = 0; m_held = 0; m_pend = 0; m_flush = 0;
    m_cnt_a = 0; m_cnt_b = 0;
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge,
  // advance the model, then wait for the next rising edge.
  task automatic cycle(input bit r, input bit e, input bit s,
                       input bit xv, input logic [31:0] xp,
                       input bit tv, input logic [31:0] tp, input bit rdy);
    bit          ev, fire, held, redir;
    logic [31:0] tgt;
    #1;
    rst = r; ena = e; stall = s;
    exu_redir_vld = xv; exu_redir_pc = xp;
    trap_vld = tv; trap_pc = tp; if_rdy = rdy;
    #4;
    ev = r ? 1'b0 : (!m_booted ? 1'b0 : (m_held ? 1'b1 : (e & ~s)));
    o_vld = fa.if_vld; o_pc = fa.if_pc; o_flush = flush_a;
    o_cnt = cnt_a; o_cnt_b = cnt_b;
    chk("vld_a",   64'(fa.if_vld), 64'(ev));
    chk("pc_a",    64'(fa.if_pc),  64'(m_pc));
    chk("flush_a", 64'(flush_a),   64'(m_flush));
    chk("cnt_a",   64'(cnt_a),     64'(m_cnt_a));
    chk("vld_b",   64'(fb.if_vld), 64'(ev));
    chk("pc_b",    64'(fb.if_pc),  64'(m_pc));
    chk("flush_b", 64'(flush_b),   64'(m_flush));
    chk("cnt_b",   64'(cnt_b),     64'(m_cnt_b));
    if (r) begin
      model_reset();
    end else begin
      fire  = ev & rdy;
      held  = ev & ~rdy;
      redir = tv | xv;
      tgt   = (tv ? tp : xp) & 32'hFFFF_FFFC;
      if (redir) begin
        if (held) begin
          m_pend = 1; m_pend_pc = tgt;
        end else begin
          m_pc = tgt; m_pend = 0;
        end
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end else if (fire) begin
        if (m_pend) begin
          m_pc = m_pend_pc; m_pend = 0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
      m_flush = redir;
      m_held  = held;
      if (e) m_booted = 1;
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 1, 0, 0, 32'h0, 0, 32'h0, rdy);
  endtask

  initial begin
    bit          r, e, s, xv, tv, rdy;
    logic [31:0] xp, tp;

    rst = 1; ena = 1; stall = 0; if_rdy = 1;
    exu_redir_vld = 0; exu_redir_pc = '0; trap_vld = 0; trap_pc = '0;
    model_reset();
    @(posedge clk);

    // Reset and boot
    repeat (3) cycle(1, 1, 0, 0, 32'h0, 0, 32'h0, 1);
    idle(1); chk("boot_vld", 64'(o_vld), 64'd0); chk("boot_pc", 64'(o_pc), 64'h0);
    idle(1); chk("seq0_pc", 64'(o_pc), 64'h0); chk("seq0_vld", 64'(o_vld), 64'd1);
    idle(1); chk("seq1_pc", 64'(o_pc), 64'h4);
    idle(1); chk("seq2_pc", 64'(o_pc), 64'h8); chk("seq2_cnt", 64'(o_cnt), 64'd0);
    idle(1);

    // Backpressure at 0x10, stall and ena dropped during the hold
    idle(0); chk("hold0_pc", 64'(o_pc), 64'h10);
    cycle(0, 1, 1, 0, 32'h0, 0, 32'h0, 0); chk("hold1_pc", 64'(o_pc), 64'h10); chk("hold1_vld", 64'(o_vld), 64'd1);
    cycle(0, 0, 1, 0, 32'h0, 0, 32'h0, 0); chk("hold2_pc", 64'(o_pc), 64'h10); chk("hold2_vld", 64'(o_vld), 64'd1);
    idle(1);
    idle(1); chk("post_hold_pc", 64'(o_pc), 64'h14);
    idle(1); idle(1);

    // Execute redirect while firing at 0x20
    cycle(0, 1, 0, 1, 32'h200, 0, 32'h0, 1); chk("redir_src_pc", 64'(o_pc), 64'h20);
    idle(1); chk("redir_pc", 64'(o_pc), 64'h200); chk("redir_flush", 64'(o_flush), 64'd1); chk("redir_cnt1", 64'(o_cnt), 64'd1);

    // Buffered trap while offer at 0x40 is held
    cycle(0, 1, 0, 1, 32'h40, 0, 32'h0, 1); chk("flush_single", 64'(o_flush), 64'd0);
    cycle(0, 1, 0, 0, 32'h0, 1, 32'h8000_0003, 0); chk("buf_pc0", 64'(o_pc), 64'h40);
    idle(0); chk("buf_pc1", 64'(o_pc), 64'h40); chk("buf_flush", 64'(o_flush), 64'd1); chk("buf_cnt", 64'(o_cnt), 64'd3);
    idle(1); chk("buf_noflush", 64'(o_flush), 64'd0);

    // Same-cycle trap and execute redirect
    cycle(0, 1, 0, 1, 32'h300, 1, 32'h100, 1); chk("buf_fire_pc", 64'(o_pc), 64'h8000_0000); chk("buf_fire_flush", 64'(o_flush), 64'd0);
    cycle(0, 1, 0, 1, 32'h500, 0, 32'h0, 0);
    chk("prio_pc", 64'(o_pc), 64'h100); chk("prio_cnt", 64'(o_cnt), 64'd4); chk("prio_cnt_b", 64'(o_cnt_b), 64'd3);

    // Two redirects overwriting one held offer
    cycle(0, 1, 0, 1, 32'h600, 0, 32'h0, 0);
    idle(1); chk("ovr_held_pc", 64'(o_pc), 64'h100);
    cycle(0, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 1);
    chk("ovr_pc", 64'(o_pc), 64'h600); chk("ovr_cnt", 64'(o_cnt), 64'd6);

    // Wrap and saturation
    idle(1); chk("wrap_src_pc", 64'(o_pc), 64'hFFFF_FFFC); chk("sat_cnt_b", 64'(o_cnt_b), 64'd3);
    idle(0); chk("wrap_pc", 64'(o_pc), 64'h0);

    // Reset while an offer is held
    cycle(1, 1, 0, 0, 32'h0, 0, 32'h0, 0); chk("rst_vld", 64'(o_vld), 64'd0);
    cycle(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    chk("rst_post_vld", 64'(o_vld), 64'd0); chk("rst_post_pc", 64'(o_pc), 64'h0);
    chk("rst_post_cnt", 64'(o_cnt), 64'd0); chk("rst_post_flush", 64'(o_flush), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(63) == 0);
      e   = ($urandom_range(9) != 0);
      s   = ($urandom_range(4) == 0);
      xv  = ($urandom_range(7) == 0);
      tv  = ($urandom_range(11) == 0);
      rdy = ($urandom_range(9) < 7);
      xp  = $urandom;
      tp  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cycle(r, e, s, xv, xp, tv, tp, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural fetch PC register and sequences instruction fetch for the rvseed core.
- Each cycle it arbitrates between:
  - trap/exception vector from the CSR unit,
  - branch/jump redirect from the execute stage,
  - hazard stall,
  - sequential pc+4.
- Presents one fetch address at a time to the IFU over a valid/ready handshake and keeps that address stable while the offer is pending.
- Generates the pipeline flush pulse and a redirect performance counter.

Parameters:
- CPU_WIDTH, 32, PC/data width (matches `CPU_WIDTH).
- RESET_PC, 32'h0000_0000, fetch address after reset.
- CNT_WIDTH, 16, width of redirect counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  global core enable; 0 freezes sequencing
- stall  in  1  hazard stall from the decode/hazard unit
- exu_redir_vld  in  1  branch taken / jump resolved in execute
- exu_redir_pc  in  CPU_WIDTH  execute redirect target
- trap_vld  in  1  trap/mret redirect from the CSR unit
- trap_pc  in  CPU_WIDTH  trap vector / mepc target
- if_vld  out  1  fetch request valid
- if_pc  out  CPU_WIDTH  fetch address
- if_rdy  in  1  IFU accepts the request
- flush  out  1  one-cycle pulse; kill IF/ID contents
- redir_cnt  out  CNT_WIDTH  accepted-redirect count, saturating

Behaviour:

Reset:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- On rst=1 at a clk edge: pc=RESET_PC, state=BOOT, pend_vld=0, pend_pc=0, flush=0, redir_cnt=0.
- Outputs during reset: if_vld=0, if_pc=RESET_PC.
- Reset overrides all other inputs, including mid-handshake; the pending offer is abandoned.

States:
- BOOT:
  - if_vld=0.
  - Goes to RUN on the first cycle with ena=1.
- RUN:
  - if_vld = ena & ~stall.
  - If if_vld & ~if_rdy, go to WAIT.
- WAIT:
  - if_vld=1 regardless of stall and ena.
  - Go to RUN when if_rdy=1.

Handshake:
- fire = if_vld & if_rdy.
- offer_held = if_vld & ~if_rdy.
- While offer_held, if_pc is held constant on the next cycle. if_pc is always the pc register (zero combinational latency from pc).

Redirect selection (priority trap_vld > exu_redir_vld):
- Target tgt = the selected source's pc with bits[1:0] forced to 0.
- If offer_held: pend_vld<=1 and pend_pc<=tgt. A newer redirect overwrites the pending one. pc is unchanged.
- Otherwise: pc<=tgt, pend_vld<=0.
- In both cases:
  - flush is asserted on the following cycle (exactly 1 cycle).
  - redir_cnt increments, saturating at all-ones.
- Redirects are accepted in every state, including BOOT, under stall, and with ena=0.

Non-redirect cycles:
- fire with pend_vld: pc<=pend_pc, pend_vld<=0, no new flush.
- fire without pend_vld: pc<=pc+4, modulo 2^CPU_WIDTH (32'hFFFF_FFFC wraps to 0).
- No fire: pc holds.

Simultaneous events:
- A redirect on a fire cycle takes priority over pend_pc and pc+4. The fired wrong-path fetch is covered by the flush.
- trap_vld and exu_redir_vld together: trap wins; counter increments once.

Decomposition:
- Shared defines file: `CPU_WIDTH, RESET_PC value, state encoding `PCSEQ_BOOT/RUN/WAIT (2 bits), `INST_BYTES (4).
- No sub-module needed. The saturating counter may be a small inline always block.
- Instantiation: MUX_PC's next_pc selection is superseded by this block in the new fetch path.

Test Plan:
- Reset/boot: hold rst 3 cycles, release with ena=1, if_rdy=1 -> if_vld rises the cycle after BOOT; if_pc sequence 0x0, 0x4, 0x8; flush=0; redir_cnt=0.
- Backpressure: if_rdy=0 for 3 cycles at pc=0x10 -> if_vld=1 and if_pc=0x10 stable throughout, even with stall=1 applied during the hold; after if_rdy=1, next if_pc=0x14.
- Redirect in RUN: exu_redir_vld=1, exu_redir_pc=0x200 while firing at 0x20 -> next if_pc=0x200; flush pulses 1 cycle; redir_cnt=1.
- Buffered redirect: offer at 0x40 held (if_rdy=0), trap_vld=1, trap_pc=0x8000_0003 -> if_pc stays 0x40; flush next cycle; on fire, if_pc=0x8000_0000 with no second flush.
- Priority/overwrite:
  - Same-cycle trap_pc=0x100 and exu_redir_pc=0x300 -> pc=0x100, count +1.
  - Two redirects (0x500 then 0x600) during one held offer -> post-fire pc=0x600.
- Wrap/saturation and reset mid-op:
  - pc=0xFFFF_FFFC fires -> if_pc=0x0.
  - CNT_WIDTH=2 bench with 5 redirects -> redir_cnt=3.
  - rst asserted in WAIT -> next cycle if_vld=0, if_pc=RESET_PC.
